fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the IR/decoder of the 16-bit datapath.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: req/ack memory port, prefetch FIFO, redirect flush
// Optional FETCH_BYPASS_EN: an acked word passes straight to decode when the FIFO is empty.
module fetch_unit #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     instr_valid,
  output logic [DATA_W-1:0]        instr_data,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              fifo_valid;
  logic              mem_done;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    count_next;
  logic              slot_free;

  assign fifo_valid = (count != '0);
  assign mem_done   = (state == BUSY) && mem_ack && !redirect;
`ifdef FETCH_BYPASS_EN
  assign bypass     = mem_done && !fifo_valid;
`else
  assign bypass     = 1'b0;
`endif
  // A bypassed word taken by decode this cycle never occupies a FIFO slot.
  assign push       = mem_done && !(bypass && instr_ready);
  assign pop        = fifo_valid && instr_ready && !redirect;
  assign count_next = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
  assign slot_free  = (count_next < DEPTH_C);

  always_comb begin
    instr_valid = fifo_valid;
    instr_data  = data_q[rd_ptr];
    instr_pc    = pc_q[rd_ptr];
    if (bypass) begin
      instr_valid = 1'b1;
      instr_data  = mem_rdata;
      instr_pc    = mem_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc;
      // An unanswered request must still complete before the new stream starts.
      case (state)
        BUSY: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      if (push) begin
        data_q[wr_ptr] <= mem_rdata;
        pc_q[wr_ptr]   <= mem_addr;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next[CNT_W-1:0];
      case (state)
        IDLE: begin
          if (slot_free) begin
            state    <= BUSY;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            fetch_pc <= fetch_pc + 1'b1;
            if (slot_free) begin
              mem_addr <= fetch_pc + 1'b1;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [15:0] KEY = 16'hC3A5;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [2:0]  count;

  int n_tests;
  int n_fail;

  fetch_unit #(
    .DEPTH   (4),
    .ADDR_W  (16),
    .DATA_W  (16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .count      (count)
  );

  // Memory returns a scrambled copy of the address so data and PC are cross-checked.
  assign mem_rdata = mem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [15:0] e;
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    mem_ack     = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    #1;
    check_eq("rst_req",   32'(mem_req),     32'd0);
    check_eq("rst_addr",  32'(mem_addr),    32'h0000);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_data",  32'(instr_data),  32'h0000);
    check_eq("rst_pc",    32'(instr_pc),    32'h0000);
    check_eq("rst_count", 32'(count),       32'd0);

    // Streaming: continuous ack and ready, one word per cycle
    @(negedge clk);
    reset       = 1'b0;
    mem_ack     = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    check_eq("first_req",   32'(mem_req),     32'd1);
    check_eq("first_addr",  32'(mem_addr),    32'h0000);
    check_eq("first_valid", 32'(instr_valid), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = 16'(k - 1);
      check_eq("stream_addr",  32'(mem_addr),    32'(16'(k)));
      check_eq("stream_valid", 32'(instr_valid), 32'd1);
      check_eq("stream_pc",    32'(instr_pc),    32'(e));
      check_eq("stream_data",  32'(instr_data),  32'(e ^ KEY));
      check_eq("stream_count", 32'(count),       32'd1);
    end

    // Asynchronous reset in the middle of BUSY
    #2;
    reset = 1'b1;
    #1;
    check_eq("areset_req",   32'(mem_req),     32'd0);
    check_eq("areset_count", 32'(count),       32'd0);
    check_eq("areset_valid", 32'(instr_valid), 32'd0);
    check_eq("areset_addr",  32'(mem_addr),    32'h0000);

    // Fill: decoder stalled, exactly DEPTH words fetched
    @(negedge clk);
    reset       = 1'b0;
    mem_ack     = 1'b1;
    instr_ready = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("full_count", 32'(count),       32'd4);
    check_eq("full_req",   32'(mem_req),     32'd0);
    check_eq("full_valid", 32'(instr_valid), 32'd1);
    check_eq("full_pc",    32'(instr_pc),    32'h0000);
    check_eq("full_data",  32'(instr_data),  32'(16'h0000 ^ KEY));

    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check_eq("pop1_count", 32'(count),    32'd3);
    check_eq("pop1_req",   32'(mem_req),  32'd1);
    check_eq("pop1_addr",  32'(mem_addr), 32'h0004);
    check_eq("pop1_pc",    32'(instr_pc), 32'h0001);
    @(negedge clk);
    check_eq("refill_count", 32'(count),   32'd4);
    check_eq("refill_req",   32'(mem_req), 32'd0);

    // Drain the FIFO with memory stalled; order must be preserved
    instr_ready = 1'b1;
    mem_ack     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = 16'(i + 1);
      check_eq("drain_valid", 32'(instr_valid), 32'd1);
      check_eq("drain_pc",    32'(instr_pc),    32'(e));
      check_eq("drain_data",  32'(instr_data),  32'(e ^ KEY));
      @(negedge clk);
    end
    check_eq("empty_valid", 32'(instr_valid), 32'd0);
    check_eq("empty_count", 32'(count),       32'd0);
    check_eq("empty_req",   32'(mem_req),     32'd1);
    check_eq("empty_addr",  32'(mem_addr),    32'h0005);
    instr_ready = 1'b0;

    // Delayed acknowledge: request held steady
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("wait_addr",  32'(mem_addr), 32'h0005);
      check_eq("wait_req",   32'(mem_req),  32'd1);
      check_eq("wait_count", 32'(count),    32'd0);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("late_count", 32'(count),    32'd1);
    check_eq("late_pc",    32'(instr_pc), 32'h0005);
    check_eq("late_data",  32'(instr_data), 32'(16'h0005 ^ KEY));
    check_eq("late_addr",  32'(mem_addr), 32'h0006);

    // Redirect with a request outstanding: drain, drop, restart at 0x0040
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("redir_count", 32'(count),       32'd0);
    check_eq("redir_valid", 32'(instr_valid), 32'd0);
    check_eq("redir_req",   32'(mem_req),     32'd1);
    check_eq("redir_addr",  32'(mem_addr),    32'h0006);
    mem_ack = 1'b1;
    @(negedge clk);
    check_eq("dropped_count", 32'(count),   32'd0);
    check_eq("dropped_req",   32'(mem_req), 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    check_eq("newreq_req",  32'(mem_req),  32'd1);
    check_eq("newreq_addr", 32'(mem_addr), 32'h0040);
    check_eq("newreq_cnt",  32'(count),    32'd0);
    @(negedge clk);
    check_eq("newpc_valid", 32'(instr_valid), 32'd1);
    check_eq("newpc_pc",    32'(instr_pc),    32'h0040);
    check_eq("newpc_data",  32'(instr_data),  32'(16'h0040 ^ KEY));
    check_eq("newpc_addr",  32'(mem_addr),    32'h0041);

    // Redirect coinciding with ack, then address wrap through 0xFFFF
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("wrapredir_req",   32'(mem_req), 32'd0);
    check_eq("wrapredir_count", 32'(count),   32'd0);
    @(negedge clk);
    check_eq("wrap_req",  32'(mem_req),  32'd1);
    check_eq("wrap_addr", 32'(mem_addr), 32'hFFFE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = 16'hFFFE + 16'(i);
      check_eq("wrap_valid", 32'(instr_valid), 32'd1);
      check_eq("wrap_pc",    32'(instr_pc),    32'(e));
      check_eq("wrap_data",  32'(instr_data),  32'(e ^ KEY));
      check_eq("wrap_next",  32'(mem_addr),    32'(16'(e + 16'd1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
